mem_arbiter: RTL and testbench

Shares the multi-cycle core's single unified instruction/data memory port between two requesters: the core (fetch, load, store) and the program loader/debug port. Arbitration is fixed priority with a starvation guard. The block keeps at most one transaction outstanding, sequences fixed-latency reads, and raises a stall that the control FSM uses to hold PCWrite and IRWrite while the core waits. It sits between the core's address mux (AdrSrc output) and the memory macro.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority core/loader arbiter for the unified memory port
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              core_stall
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_LIM + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             pend_q, pend_d;
  logic             own_l_q, own_l_d;
  logic             can_grant, gnt_c, gnt_l, rsp_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      pend_q   <= 1'b0;
      own_l_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      own_l_q  <= own_l_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    pend_d   = pend_q;
    own_l_d  = own_l_q;
    gnt_c    = 1'b0;
    gnt_l    = 1'b0;
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;

    // With MEM_LAT==1 the response cycle is an IDLE cycle with a pending read.
    rsp_fire  = pend_q && ((state_q == IDLE) || (cnt_q == '0));
    can_grant = (state_q == IDLE) || (cnt_q == '0);

    if (rsp_fire)
      pend_d = 1'b0;
    if (state_q == WAIT) begin
      if (cnt_q == '0)
        state_d = IDLE;
      else
        cnt_d = cnt_q - CNT_W'(1);
    end

    if (can_grant && !rst) begin
      if (l_req && !(c_req && (starve_q == STV_W'(STARVE_LIM))))
        gnt_l = 1'b1;
      else if (c_req)
        gnt_c = 1'b1;
    end

    if (gnt_l) begin
      m_en    = 1'b1;
      m_we    = l_we;
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end else if (gnt_c) begin
      m_en    = 1'b1;
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end

    // A read issued in the response cycle re-arms the pending flag.
    if (m_en && !m_we) begin
      pend_d  = 1'b1;
      own_l_d = gnt_l;
      cnt_d   = CNT_W'(MEM_LAT - 1);
      state_d = (MEM_LAT > 1) ? WAIT : IDLE;
    end

    if (gnt_c || !c_req)
      starve_d = '0;
    else if (gnt_l && (starve_q != STV_W'(STARVE_LIM)))
      starve_d = starve_q + STV_W'(1);
  end

  assign c_gnt      = gnt_c;
  assign l_gnt      = gnt_l;
  assign c_rvalid   = rsp_fire && !own_l_q && !rst;
  assign l_rvalid   = rsp_fire && own_l_q && !rst;
  assign c_rdata    = m_rdata;
  assign l_rdata    = m_rdata;
  assign core_stall = c_req && !gnt_c && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter against a cycle-level reference model
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int SLIM = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] c_addr = '0, l_addr = '0;
  logic [DW-1:0] c_wdata = '0, l_wdata = '0, m_rdata = '0;
  logic          c_gnt, c_rvalid, l_gnt, l_rvalid, m_en, m_we, core_stall;
  logic [DW-1:0] c_rdata, l_rdata, m_wdata;
  logic [AW-1:0] m_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIM(SLIM)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .core_stall(core_stall)
  );

  typedef struct {
    logic [1:0]    gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall;
  } cyc_exp_t;

  typedef struct {
    logic [1:0]    owner;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  typedef struct {
    logic          act;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } rq_t;

  cyc_exp_t      exp_cyc_q[$];
  rsp_t          exp_rsp_q[$];
  logic [1:0]    gnt_log[$];
  logic [DW-1:0] mem[16];
  logic [DW-1:0] mirror[16];
  logic [DW-1:0] rd_pipe[int];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            free_cyc = 0;
  int            starve = 0;
  rq_t           cr, lr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro: reads return MEM_LAT cycles after the strobe, garbage otherwise.
  always @(negedge clk) begin
    if (m_en && m_we)
      mem[m_addr[5:2]] = m_wdata;
    else if (m_en)
      rd_pipe[cyc + LAT] = mem[m_addr[5:2]];
  end

  always @(posedge clk) begin
    #1;
    if (rd_pipe.exists(cyc)) begin
      m_rdata = rd_pipe[cyc];
      rd_pipe.delete(cyc);
    end else begin
      m_rdata = $urandom;
    end
  end

  cyc_exp_t mon_e;
  rsp_t     mon_r;

  always @(negedge clk) begin
    if (exp_cyc_q.size() > 0) begin
      mon_e = exp_cyc_q.pop_front();
      gnt_log.push_back({c_gnt, l_gnt});
      chk("gnt", {62'd0, c_gnt, l_gnt}, {62'd0, mon_e.gnt});
      chk("m_en", {63'd0, m_en}, {63'd0, mon_e.gnt != 2'b00});
      chk("m_we", {63'd0, m_we}, {63'd0, mon_e.we});
      chk("m_addr", {32'd0, m_addr}, {32'd0, mon_e.addr});
      chk("m_wdata", {32'd0, m_wdata}, {32'd0, mon_e.wdata});
      chk("core_stall", {63'd0, core_stall}, {63'd0, mon_e.stall});
    end
    if (c_rvalid || l_rvalid) begin
      if (exp_rsp_q.size() == 0) begin
        chk("rvalid_unexpected", {62'd0, c_rvalid, l_rvalid}, 64'd0);
      end else begin
        mon_r = exp_rsp_q.pop_front();
        chk("rvalid_owner", {62'd0, c_rvalid, l_rvalid}, {62'd0, mon_r.owner});
        chk("rvalid_cycle", 64'(cyc), 64'(mon_r.due));
        chk("rdata", {32'd0, (c_rvalid ? c_rdata : l_rdata)}, {32'd0, mon_r.data});
      end
    end else if (exp_rsp_q.size() > 0 && exp_rsp_q[0].due <= cyc) begin
      mon_r = exp_rsp_q.pop_front();
      chk("rvalid_missing", 64'd0, {62'd0, mon_r.owner});
    end
  end

  // Reference model: a port is free once the previous read's latency has elapsed.
  task automatic step(input logic r, output int g);
    cyc_exp_t e;
    rq_t      w;
    @(posedge clk);
    #1;
    rst = r;
    c_req = cr.act; c_we = cr.we; c_addr = cr.addr; c_wdata = cr.wdata;
    l_req = lr.act; l_we = lr.we; l_addr = lr.addr; l_wdata = lr.wdata;
    g = 0;
    e.gnt = 2'b00; e.we = 1'b0; e.addr = '0; e.wdata = '0; e.stall = 1'b0;
    if (r) begin
      starve = 0;
      free_cyc = 0;
      exp_rsp_q.delete();
    end else begin
      if (cyc >= free_cyc) begin
        if (lr.act && !(cr.act && starve == SLIM)) g = 2;
        else if (cr.act) g = 1;
      end
      if (g != 0) begin
        w = (g == 1) ? cr : lr;
        e.gnt = (g == 1) ? 2'b10 : 2'b01;
        e.we = w.we; e.addr = w.addr; e.wdata = w.wdata;
        if (w.we) begin
          mirror[w.addr[5:2]] = w.wdata;
        end else begin
          exp_rsp_q.push_back('{e.gnt, mirror[w.addr[5:2]], cyc + LAT});
          free_cyc = cyc + LAT;
        end
      end
      e.stall = cr.act && (g != 1);
      if (g == 1 || !cr.act) starve = 0;
      else if (g == 2 && starve < SLIM) starve++;
    end
    exp_cyc_q.push_back(e);
  endtask

  function automatic rq_t mk(input logic act, input logic we, input int idx, input logic [DW-1:0] d);
    rq_t q;
    q.act = act; q.we = we; q.addr = AW'(idx * 4); q.wdata = d;
    return q;
  endfunction

  function automatic rq_t rand_rq();
    return mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
  endfunction

  initial begin
    int g;
    logic [1:0] order[6];
    order = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 16; i++) begin
      mem[i] = DW'(32'hA5000000 + i * 32'h111);
      mirror[i] = mem[i];
    end

    // Reset held with both requesting, then the loader wins first.
    cr = mk(1, 1, 1, 32'h11111111);
    lr = mk(1, 1, 2, 32'h22222222);
    step(1, g); step(1, g);
    step(0, g);
    cr.act = 0; lr.act = 0;
    step(0, g);

    // Continuous writes from both: starvation guard lets the core in every third grant.
    cr = mk(1, 1, 3, 32'h33333333);
    lr = mk(1, 1, 4, 32'h44444444);
    @(negedge clk); #1;
    gnt_log.delete();
    for (int i = 0; i < 6; i++) step(0, g);
    @(negedge clk); #1;
    for (int i = 0; i < 6; i++)
      chk("starve_order", {62'd0, gnt_log[i]}, {62'd0, order[i]});
    cr.act = 0; lr.act = 0;

    for (int i = 0; i < 4; i++) begin
      cr = mk(1, 1, i, DW'(32'hC0DE0000 + i));
      step(0, g);
    end
    cr.act = 0;

    // Loader read, core write waiting from the next cycle lands in the rvalid cycle.
    lr = mk(1, 0, 2, '0);
    step(0, g);
    lr.act = 0;
    cr = mk(1, 1, 5, 32'h55555555);
    for (int i = 0; i < 3; i++) step(0, g);
    cr.act = 0;
    step(0, g);

    // Reset one cycle after a core read: the read is abandoned.
    cr = mk(1, 0, 3, '0);
    step(0, g);
    cr.act = 0;
    step(1, g);
    cr = mk(1, 1, 6, 32'h66666666);
    step(0, g);
    cr.act = 0;
    for (int i = 0; i < LAT; i++) step(0, g);

    cr = rand_rq();
    lr = rand_rq();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), g);
      if (g == 1 || !cr.act) cr = rand_rq();
      if (g == 2 || !lr.act) lr = rand_rq();
    end

    cr.act = 0; lr.act = 0;
    for (int i = 0; i < LAT + 2; i++) step(0, g);
    @(negedge clk); #1;
    chk("rsp_drain", 64'(exp_rsp_q.size()), 64'd0);
    chk("cyc_drain", 64'(exp_cyc_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
